// File: rtl/frame_pkg.sv
// Types and helpers shared by the frame-buffer writer and reader.
package frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } reader_state_e;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } pix_flags_t;

    localparam int unsigned PIX_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        pix_flags_t       flags;
    } pixel_t;

    function automatic int addr_w(input int pixels);
        return (pixels > 1) ? $clog2(pixels) : 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; the head entry is read straight from storage flops.
// The count output lets the producer apply credit-based flow control.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop      = rd_en && (count_q != '0);
    // A write into a full FIFO is only taken when the head leaves in the same cycle.
    assign push     = wr_en && ((count_q != CW'(DEPTH)) || pop);
    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// Streams a stored frame out of a fixed-latency BRAM read port as a valid/ready pixel stream.
// Define FRAME_READER_LOOP_EN to restream frames continuously after a single start.
module bram_frame_reader
    import frame_pkg::*;
#(
    parameter int unsigned IMG_WIDTH    = 640,
    parameter int unsigned IMG_HEIGHT   = 480,
    parameter int unsigned W            = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned ADDR_W       = addr_w(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              frame_done,
    output logic              bram_re,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [W-1:0]      bram_rdata,
    output logic              y_valid,
    input  logic              y_ready,
    output logic [W-1:0]      y_data,
    output logic              y_sof,
    output logic              y_eol,
    output logic              y_eof
);

    localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned COL_W = addr_w(IMG_WIDTH);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FLW   = $bits(pix_flags_t);
    localparam int unsigned FW    = W + FLW;

    reader_state_e           state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [CW-1:0]           in_flight_q, in_flight_d;
    logic [CW-1:0]           fifo_count;
    logic                    eof_seen_q, eof_seen_d;
    logic [READ_LATENCY-1:0] rv_q;
    pix_flags_t              flags_q [READ_LATENCY];
    pix_flags_t              issue_flags, out_flags;
    logic [FW-1:0]           fifo_rdata;
    logic                    credit, issue, push, beat, last_addr, done, restart;

    // Reads still in the BRAM pipeline already own a FIFO slot.
    assign credit    = ({1'b0, in_flight_q} + {1'b0, fifo_count}) < (CW + 1)'(FIFO_DEPTH);
    assign issue     = (state_q == StRun) && credit;
    assign push      = rv_q[READ_LATENCY-1];
    assign beat      = y_valid && y_ready;
    assign last_addr = (addr_q == ADDR_W'(NPIX - 1));
    assign done      = (state_q == StDrain) && (in_flight_q == '0) && (fifo_count == '0)
                       && eof_seen_q;
    assign restart   = ((state_q == StIdle) && start) || done;

    assign issue_flags.sof = (addr_q == '0);
    assign issue_flags.eol = (col_q == COL_W'(IMG_WIDTH - 1));
    assign issue_flags.eof = last_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (issue && last_addr) state_d = StDrain;
`ifdef FRAME_READER_LOOP_EN
            StDrain: if (done) state_d = StRun;
`else
            StDrain: if (done) state_d = StIdle;
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy       = (state_q != StIdle);
        frame_done = done;
        bram_re    = issue;
        bram_addr  = addr_q;
    end

    always_comb begin
        addr_d      = addr_q;
        col_d       = col_q;
        eof_seen_d  = eof_seen_q;
        in_flight_d = in_flight_q;
        if (restart) begin
            addr_d = '0;
            col_d  = '0;
        end else if (issue) begin
            addr_d = addr_q + 1'b1;
            col_d  = (col_q == COL_W'(IMG_WIDTH - 1)) ? '0 : col_q + 1'b1;
        end
        if (beat && y_eof) eof_seen_d = 1'b1;
        if (restart) eof_seen_d = 1'b0;
        if (issue && !push) begin
            in_flight_d = in_flight_q + 1'b1;
        end else if (push && !issue) begin
            in_flight_d = in_flight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            col_q       <= '0;
            eof_seen_q  <= 1'b0;
            in_flight_q <= '0;
        end else begin
            addr_q      <= addr_d;
            col_q       <= col_d;
            eof_seen_q  <= eof_seen_d;
            in_flight_q <= in_flight_d;
        end
    end

    // Valid bit and flags ride alongside the BRAM read so they meet their data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                flags_q[i] <= '0;
            end
        end else begin
            rv_q[0]    <= issue;
            flags_q[0] <= issue_flags;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rv_q[i]    <= rv_q[i-1];
                flags_q[i] <= flags_q[i-1];
            end
        end
    end

    sync_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_DEPTH),
        .CW   (CW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data ({bram_rdata, flags_q[READ_LATENCY-1]}),
        .rd_en   (y_ready),
        .rd_data (fifo_rdata),
        .rd_valid(y_valid),
        .count   (fifo_count)
    );

    assign out_flags = pix_flags_t'(fifo_rdata[FLW-1:0]);
    assign y_data    = fifo_rdata[FW-1-:W];
    assign y_sof     = y_valid && out_flags.sof;
    assign y_eol     = y_valid && out_flags.eol;
    assign y_eof     = y_valid && out_flags.eof;

endmodule

// File: tb/tb_bram_frame_reader.sv
// Bench for bram_frame_reader: a 4x2 frame read through latency-1 and latency-2 instances.
module tb_bram_frame_reader;

    localparam int unsigned IW    = 4;
    localparam int unsigned IH    = 2;
    localparam int unsigned NPIX  = IW * IH;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eol;
        logic       eof;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] busy, done, re, valid, sof, eol, eof;
    logic [2:0] addr  [2];
    logic [7:0] rdata [2];
    logic [7:0] ydata [2];
    logic [7:0] mem   [NPIX];
    logic [7:0] pipe2;

    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   rd_idx [2];
    int   iss [2];
    int   beats [2];
    int   done_cnt [2];
    int   first_re [2];
    int   first_valid [2];
    int   eof_k [2];
    logic [1:0] held_v = '0;
    exp_t held [2];
    exp_t sb [$];
    int   mk;
    exp_t mobs;

    always #5 clk = ~clk;

    bram_frame_reader #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8), .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy[0]), .frame_done(done[0]),
        .bram_re(re[0]), .bram_addr(addr[0]), .bram_rdata(rdata[0]), .y_valid(valid[0]),
        .y_ready(ready), .y_data(ydata[0]), .y_sof(sof[0]), .y_eol(eol[0]), .y_eof(eof[0])
    );

    bram_frame_reader #(
        .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8), .READ_LATENCY(2), .FIFO_DEPTH(DEPTH)
    ) u_dut_l2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy[1]), .frame_done(done[1]),
        .bram_re(re[1]), .bram_addr(addr[1]), .bram_rdata(rdata[1]), .y_valid(valid[1]),
        .y_ready(ready), .y_data(ydata[1]), .y_sof(sof[1]), .y_eol(eol[1]), .y_eof(eof[1])
    );

    // BRAM models: one and two cycles of read latency.
    always @(posedge clk) begin
        if (re[0]) rdata[0] <= mem[addr[0]];
        if (re[1]) pipe2 <= mem[addr[1]];
        rdata[1] <= pipe2;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: scoreboard pops, stall stability, credit bound, frame_done timing.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            held_v = '0;
            for (int d = 0; d < 2; d++) begin
                iss[d]   = 0;
                beats[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                mk   = cyc - t0;
                mobs = {ydata[d], sof[d], eol[d], eof[d]};
                if (held_v[d] && valid[d]) check($sformatf("hold_l%0d", d + 1), mobs, held[d]);
                if (re[d]) begin
                    check($sformatf("credit_l%0d", d + 1),
                          32'((iss[d] - beats[d] + 1) <= DEPTH), 1);
                    if (first_re[d] < 0) first_re[d] = mk;
                    iss[d]++;
                end
                if (valid[d] && first_valid[d] < 0) first_valid[d] = mk;
                if (valid[d] && ready) begin
                    if (rd_idx[d] < sb.size()) begin
                        check($sformatf("beat%0d_l%0d", beats[d], d + 1), mobs, sb[rd_idx[d]]);
                        rd_idx[d]++;
                    end else begin
                        check($sformatf("extra_beat_l%0d", d + 1), 1, 0);
                    end
                    beats[d]++;
                    if (eof[d]) eof_k[d] = mk;
                end
                held_v[d] = valid[d] && !ready;
                held[d]   = mobs;
                if (done[d]) begin
                    done_cnt[d]++;
                    check($sformatf("done_after_eof_l%0d", d + 1), mk - eof_k[d], 1);
                end
            end
            while (sb.size() > 0 && rd_idx[0] > 0 && rd_idx[1] > 0) begin
                void'(sb.pop_front());
                rd_idx[0]--;
                rd_idx[1]--;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            iss[d]         = 0;
            beats[d]       = 0;
            done_cnt[d]    = 0;
            first_re[d]    = -1;
            first_valid[d] = -1;
            eof_k[d]       = -1;
        end
    endtask

    task automatic push_frame();
        exp_t e;
        for (int i = 0; i < NPIX; i++) begin
            e.data = 8'(i);
            e.sof  = (i == 0);
            e.eol  = ((i % IW) == IW - 1);
            e.eof  = (i == NPIX - 1);
            sb.push_back(e);
        end
    endtask

    task automatic kick();
        push_frame();
        step(1);
        start = 1'b1;
        t0    = cyc;
        step(1);
        start = 1'b0;
    endtask

    task automatic run_until_done(input int target, input int budget, input bit rnd);
        int n = 0;
        while ((done_cnt[0] < target || done_cnt[1] < target) && n < budget) begin
            if (rnd) ready = 1'($urandom_range(0, 1));
            step(1);
            n++;
        end
        check("done_within_budget", 32'(n < budget), 1);
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_ctl_l%0d", tag, d + 1),
                  {busy[d], done[d], re[d], valid[d], sof[d], eol[d], eof[d]}, 0);
            check($sformatf("%s_addr_l%0d", tag, d + 1), addr[d], 0);
            check($sformatf("%s_data_l%0d", tag, d + 1), ydata[d], 0);
        end
    endtask

    task automatic check_frame_end(input string tag, input int frames);
        check($sformatf("%s_sb_empty", tag), sb.size(), 0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_beats_l%0d", tag, d + 1), beats[d], frames * NPIX);
            check($sformatf("%s_dones_l%0d", tag, d + 1), done_cnt[d], frames);
        end
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        rd_idx[0] = 0;
        rd_idx[1] = 0;
        clear_stats();
        rst = 1'b1;
        step(3);
        @(negedge clk);
        check_idle("reset");
        step(1);
        rst = 1'b0;
        step(2);

`ifdef FRAME_READER_LOOP_EN
        ready = 1'b1;
        clear_stats();
        push_frame();
        kick();
        run_until_done(2, 100, 1'b0);
        rst = 1'b1;
        check_frame_end("loop", 2);
        check("loop_busy_before_rst", busy, 2'b11);
        step(2);
        rst = 1'b0;
`else
        // Full-rate frame with exact cycle timing.
        ready = 1'b1;
        clear_stats();
        kick();
        run_until_done(1, 60, 1'b0);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("first_re_l%0d", d + 1), first_re[d], 1);
            check($sformatf("first_valid_l%0d", d + 1), first_valid[d], d + 3);
            check($sformatf("last_beat_l%0d", d + 1), eof_k[d], NPIX + d + 2);
        end
        check_frame_end("full_rate", 1);
        step(2);
        check("idle_after_frame", busy, 0);

        // Random backpressure.
        clear_stats();
        kick();
        run_until_done(1, 400, 1'b1);
        check_frame_end("random_ready", 1);
        ready = 1'b1;
        step(2);

        // Long stall right after start.
        clear_stats();
        ready = 1'b0;
        kick();
        step(19);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("stall_reads_l%0d", d + 1), 32'(iss[d] > 0 && iss[d] <= DEPTH), 1);
            check($sformatf("stall_beats_l%0d", d + 1), beats[d], 0);
        end
        ready = 1'b1;
        run_until_done(1, 60, 1'b0);
        check_frame_end("stall", 1);
        step(2);

        // Second start while running is ignored.
        clear_stats();
        kick();
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        run_until_done(1, 60, 1'b0);
        step(10);
        check_frame_end("restart_ignored", 1);
        check("restart_busy", busy, 0);

        // Reset mid-frame, then a clean frame.
        clear_stats();
        begin
            int n = 0;
            kick();
            while (beats[0] < 3 && n < 30) begin
                step(1);
                n++;
            end
            check("reach_beat3", 32'(n < 30), 1);
        end
        rst = 1'b1;
        sb.delete();
        rd_idx[0] = 0;
        rd_idx[1] = 0;
        @(negedge clk);
        check_idle("mid_reset");
        step(2);
        rst = 1'b0;
        step(1);
        clear_stats();
        kick();
        run_until_done(1, 60, 1'b0);
        check_frame_end("after_reset", 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
